// File: rtl/mul_wb_if.sv
// Register-file write port driven by the multiply writeback stage.
// Handshake: a write transfers on any clock edge where wr_valid && wr_ready; once raised, wr_valid, wr_sel and wr_data hold until that transfer.
interface mul_wb_if #(
  parameter int WORD_BITS = 30
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic                 wr_sel;
  logic [WORD_BITS:0]   wr_data;

  modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);
endinterface

// File: rtl/mul_wb.sv
// MIX MUL writeback: captures the product on mul_stop, writes rA (high word) then rX (low word),
// pulses done, and flags products that arrive while a writeback is still in flight.
module mul_wb #(
  parameter int WORD_BITS = 30,
  parameter int RA_SEL    = 0,
  parameter int RX_SEL    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mul_stop,
  input  logic [2*WORD_BITS-1:0] mul_out,
  input  logic                   mul_sign,
  mul_wb_if.master               wr,
  output logic                   busy,
  output logic                   done,
  output logic                   zero,
  output logic                   overrun,
  input  logic                   clr_ovr,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, WR_A = 2'd1, WR_X = 2'd2, DONE = 2'd3} state_t;

  state_t                 state;
  logic [WORD_BITS-1:0]   lo_q;
  logic                   sgn_q;
  logic                   writing;

  assign state_dbg = state;
  assign writing   = (state == WR_A) || (state == WR_X);

  // The high word goes straight into wr_data at capture, so only the low word and sign need holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lo_q        <= '0;
      sgn_q       <= 1'b0;
      wr.wr_valid <= 1'b0;
      wr.wr_sel   <= 1'(RA_SEL);
      wr.wr_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      zero        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr_ovr)
        overrun <= 1'b0;
      // Set after clear so a coincident overrun wins.
      if (mul_stop && writing)
        overrun <= 1'b1;

      case (state)
        IDLE, DONE: begin
          if (mul_stop) begin
            state       <= WR_A;
            lo_q        <= mul_out[WORD_BITS-1:0];
            sgn_q       <= mul_sign;
            zero        <= (mul_out == '0);
            wr.wr_valid <= 1'b1;
            wr.wr_sel   <= 1'(RA_SEL);
            wr.wr_data  <= {mul_sign, mul_out[2*WORD_BITS-1:WORD_BITS]};
            busy        <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        WR_A: begin
          if (wr.wr_ready) begin
            state      <= WR_X;
            wr.wr_sel  <= 1'(RX_SEL);
            wr.wr_data <= {sgn_q, lo_q};
          end
        end
        WR_X: begin
          if (wr.wr_ready) begin
            state       <= DONE;
            wr.wr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
